// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 multiply issue/response controller.
package fpu_pkg;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} mulc_state_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    // fflags bit positions, {NV,DZ,OF,UF,NX}
    localparam int unsigned FF_NX = 0;
    localparam int unsigned FF_UF = 1;
    localparam int unsigned FF_OF = 2;
    localparam int unsigned FF_DZ = 3;
    localparam int unsigned FF_NV = 4;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;
    localparam logic [2:0] DYN = 3'b111;

    function automatic logic frm_invalid(input logic [2:0] frm);
        return (frm == 3'b101) || (frm == 3'b110) || (frm == 3'b111);
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational binary32 operand classifier (sign not needed, so not taken).
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [30:0] op,
    output fp_class_t   cls
);

    always_comb begin
        cls = NORM;
        if (op[30:23] == 8'h00)
            cls = (op[22:0] == 23'd0) ? ZERO : SUB;
        else if (op[30:23] == 8'hFF) begin
            if (op[22:0] == 23'd0)
                cls = INF;
            else
                cls = op[22] ? QNAN : SNAN;
        end
    end

endmodule

// File: rtl/fpu_mul_ctrl.sv
// Issue/response controller in front of the 2-cycle FP32 multiplier.
// Optional exponent range pre-check: define FPU_MUL_CTRL_EXP_RANGE_EN.
module fpu_mul_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_opa,
    input  logic [31:0]      req_opb,
    input  logic [2:0]       req_frm,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [2:0]       csr_frm,
    output logic             mul_start,
    output logic [31:0]      mul_opa,
    output logic [31:0]      mul_opb,
    output logic [2:0]       mul_frm,
    input  logic [31:0]      mul_result,
    input  logic             mul_nx,
    input  logic             mul_done,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic [4:0]       resp_fflags,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    mulc_state_t      state;
    logic [CNT_W-1:0] cnt;

    logic [2:0]  frm_res_c;
    fp_class_t   cls_a_c;
    fp_class_t   cls_b_c;
    logic        sign_c;
    logic        zero_a_c, zero_b_c, inf_a_c, inf_b_c, nan_c, snan_c;
    logic        special_c;
    logic [31:0] spec_res_c;
    logic [4:0]  spec_ff_c;

    fpu_classify u_cls_a (.op(req_opa[30:0]), .cls(cls_a_c));
    fpu_classify u_cls_b (.op(req_opb[30:0]), .cls(cls_b_c));

    assign frm_res_c = (req_frm == DYN) ? csr_frm : req_frm;
    assign sign_c    = req_opa[31] ^ req_opb[31];
    assign zero_a_c  = (cls_a_c == ZERO) || (cls_a_c == SUB);
    assign zero_b_c  = (cls_b_c == ZERO) || (cls_b_c == SUB);
    assign inf_a_c   = (cls_a_c == INF);
    assign inf_b_c   = (cls_b_c == INF);
    assign snan_c    = (cls_a_c == SNAN) || (cls_b_c == SNAN);
    assign nan_c     = snan_c || (cls_a_c == QNAN) || (cls_b_c == QNAN);

`ifdef FPU_MUL_CTRL_EXP_RANGE_EN
    logic [9:0] exp_c;
    logic       to_inf_c;
    assign exp_c    = 10'(req_opa[30:23]) + 10'(req_opb[30:23]) - 10'd127;
    assign to_inf_c = (frm_res_c == RNE) || (frm_res_c == RMM) ||
                      ((frm_res_c == RUP) && !sign_c) || ((frm_res_c == RDN) && sign_c);
`endif

    // Resolve everything that never needs the multiplier
    always_comb begin
        special_c  = 1'b1;
        spec_res_c = CANON_NAN;
        spec_ff_c  = 5'd0;
        if (frm_invalid(frm_res_c))
            spec_ff_c[FF_NV] = 1'b1;
        else if (nan_c)
            spec_ff_c[FF_NV] = snan_c;
        else if ((inf_a_c && zero_b_c) || (zero_a_c && inf_b_c))
            spec_ff_c[FF_NV] = 1'b1;
        else if (inf_a_c || inf_b_c)
            spec_res_c = {sign_c, 8'hFF, 23'd0};
        else if (zero_a_c || zero_b_c)
            spec_res_c = {sign_c, 31'd0};
        else begin
`ifdef FPU_MUL_CTRL_EXP_RANGE_EN
            if ($signed(exp_c) >= 10'sd255) begin
                spec_ff_c[FF_OF] = 1'b1;
                spec_ff_c[FF_NX] = 1'b1;
                spec_res_c = to_inf_c ? {sign_c, 8'hFF, 23'd0} : {sign_c, 31'h7F7FFFFF};
            end else if ($signed(exp_c) <= 10'sd0) begin
                spec_ff_c[FF_UF] = 1'b1;
                spec_ff_c[FF_NX] = 1'b1;
                spec_res_c = {sign_c, 31'd0};
            end else
                special_c = 1'b0;
`else
            special_c = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            mul_start   <= 1'b0;
            mul_opa     <= 32'd0;
            mul_opb     <= 32'd0;
            mul_frm     <= 3'd0;
            resp_valid  <= 1'b0;
            resp_result <= 32'd0;
            resp_fflags <= 5'd0;
            resp_tag    <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    resp_tag  <= req_tag;
                    resp_err  <= 1'b0;
                    mul_opa   <= req_opa;
                    mul_opb   <= req_opb;
                    mul_frm   <= frm_res_c;
                    cnt       <= '0;
                    if (special_c) begin
                        resp_result <= spec_res_c;
                        resp_fflags <= spec_ff_c;
                        resp_valid  <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        mul_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mul_done) begin
                        resp_result <= mul_result;
                        resp_fflags <= 5'(mul_nx);
                        mul_start   <= 1'b0;
                        state       <= S_DRAIN;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        resp_result <= CANON_NAN;
                        resp_fflags <= 5'd0;
                        resp_err    <= 1'b1;
                        mul_start   <= 1'b0;
                        state       <= S_DRAIN;
                    end else
                        cnt <= cnt + CNT_W'(1);
                end
                // multiplier holds done until it sees start low
                S_DRAIN: if (!mul_done) begin
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
